cla_serial_subtractor: RTL and testbench

Multi-cycle, multi-word subtractor: computes D = A − B − Bin over a WIDTH-bit operand, one 16-bit carry-lookahead slice per clock, with a borrow chained between slices. It is the subtraction counterpart of the 16-bit carry-lookahead adder in the arithmetic datapath. Wide operands reuse a single 16-bit CLA slice instead of a full-width adder. A Start/Busy/Done handshake connects it to the controlling sequencer.

---
 rtl/cla_serial_subtractor.sv | 193 +++++++++++++++++++
 tb/tb_cla_serial_subtractor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cla_serial_subtractor.sv
// Multi-word subtractor D = A - B - Bin, one 16-bit carry-lookahead slice per clock.
// Define SUB_FLAGS_EN to build the Zero/Neg/Ovf flag registers; otherwise they read 0.
module cla_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);

    localparam int N     = WIDTH / 16;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;
    logic               bout_q, bout_d;

    logic [15:0]        cla_a, cla_b, cla_sum;
    logic               cla_cin, cla_cout;
    logic               last_slice, finish;

    // ---------------- 16-bit carry-lookahead slice ----------------
    logic [15:0] g, p, c;
    logic [3:0]  grp_g, grp_p, grp_c;

    assign g = cla_a & cla_b;
    assign p = cla_a ^ cla_b;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grp
            assign c[4*gi]   = grp_c[gi];
            assign c[4*gi+1] = g[4*gi] | (p[4*gi] & grp_c[gi]);
            assign c[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi])
                             | (p[4*gi+1] & p[4*gi] & grp_c[gi]);
            assign c[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & g[4*gi+1])
                             | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                             | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & grp_c[gi]);
            assign grp_g[gi] = g[4*gi+3] | (p[4*gi+3] & g[4*gi+2])
                             | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                             | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
            assign grp_p[gi] = &p[4*gi +: 4];
        end
    endgenerate

    // Second lookahead level across the four 4-bit groups.
    assign grp_c[0] = cla_cin;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & cla_cin);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cla_cin);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & cla_cin);
    assign cla_cout = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cla_cin);
    assign cla_sum  = p ^ c;

    // ---------------- Slice operand selection ----------------
    always_comb begin
        cla_a = '0;
        cla_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cla_a = a_q[16*i +: 16];
                cla_b = ~b_q[16*i +: 16];
            end
        end
    end

    assign cla_cin    = carry_q;
    assign last_slice = (idx_q == IDX_W'(N - 1));
    assign finish     = (state_q == RUN) && last_slice;

    // ---------------- Control FSM and datapath next-state ----------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = ~Bin;
                    idx_d   = '0;
                    d_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) d_d[16*i +: 16] = cla_sum;
                end
                carry_d = cla_cout;
                idx_d   = idx_q + 1'b1;
                if (last_slice) begin
                    bout_d  = ~cla_cout;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b1;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            bout_q  <= bout_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign Done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;

`ifdef SUB_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;
    logic ovf_q, ovf_d;

    // Flags are evaluated on the completed difference as it is written.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (finish) begin
            zero_d = (d_d == '0);
            neg_d  = d_d[WIDTH-1];
            ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Zero = zero_q;
    assign Neg  = neg_q;
    assign Ovf  = ovf_q;
`else
    assign Zero = 1'b0;
    assign Neg  = 1'b0;
    assign Ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Randomized and directed bench for cla_serial_subtractor (WIDTH = 32) against an arithmetic model.
module tb_cla_serial_subtractor;

    localparam int WIDTH = 32;

    logic              Clk, Reset, Start, Bin;
    logic [WIDTH-1:0]  A, B;
    logic              Busy, Done, Bout, Zero, Neg, Ovf;
    logic [WIDTH-1:0]  D;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_d;
    logic        exp_bout, exp_zero, exp_neg, exp_ovf;

    cla_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Bin(Bin),
        .Busy(Busy), .Done(Done), .D(D), .Bout(Bout),
        .Zero(Zero), .Neg(Neg), .Ovf(Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide-integer arithmetic on the operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        longint unsigned ua, ub;
        longint          sr;
        ua       = longint'(a);
        ub       = longint'(b);
        exp_bout = (ua < ub + longint'(bin));
        exp_d    = 32'(ua - ub - longint'(bin));
        sr       = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
`ifdef SUB_FLAGS_EN
        exp_zero = (exp_d == 32'd0);
        exp_neg  = exp_d[31];
        exp_ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`else
        exp_zero = 1'b0;
        exp_neg  = 1'b0;
        exp_ovf  = (sr == 64'sd0) && 1'b0;
`endif
    endtask

    // Caller guarantees the DUT is idle and we are away from a clock edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
        Start = 1'b1; A = a; B = b; Bin = bin;
        model(a, b, bin);
        @(posedge Clk); #1;
        Start = 1'b0; A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
        check("busy_after_start", 64'(Busy), 64'd1);
        check("done_after_start", 64'(Done), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int exp_edges);
        int cnt  = 0;
        bit seen = 0;
        while (!seen && cnt < 10) begin
            @(posedge Clk); #1;
            cnt++;
            if (Done === 1'b1) seen = 1;
            else check({tag, "_busy"}, 64'(Busy), 64'd1);
        end
        check({tag, "_latency"}, 64'(cnt), 64'(exp_edges));
        if (seen) begin
            check({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
            check({tag, "_d"},    64'(D),    64'(exp_d));
            check({tag, "_bout"}, 64'(Bout), 64'(exp_bout));
            check({tag, "_zero"}, 64'(Zero), 64'(exp_zero));
            check({tag, "_neg"},  64'(Neg),  64'(exp_neg));
            check({tag, "_ovf"},  64'(Ovf),  64'(exp_ovf));
        end
        $display("[TB] %s D=%08h Bout=%b Z=%b N=%b V=%b edges=%0d", tag, D, Bout, Zero, Neg, Ovf, cnt);
    endtask

    task automatic check_idle_edge(input string tag);
        @(posedge Clk); #1;
        check({tag, "_done_fall"}, 64'(Done), 64'd0);
        check({tag, "_d_held"},    64'(D),    64'(exp_d));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_done"}, 64'(Done), 64'd0);
        check({tag, "_d"},    64'(D),    64'd0);
        check({tag, "_bout"}, 64'(Bout), 64'd0);
        check({tag, "_zero"}, 64'(Zero), 64'd0);
        check({tag, "_neg"},  64'(Neg),  64'd0);
        check({tag, "_ovf"},  64'(Ovf),  64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int idle;
        Reset = 1'b0; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        #2 Reset = 1'b1;
        #8;
        check_cleared("reset");
        @(negedge Clk); Reset = 1'b0;

        start_op(32'h12345678, 32'h02345678, 1'b0);
        wait_done("basic", 2);
        check_idle_edge("basic");

        start_op(32'h00010000, 32'h00000001, 1'b0);
        wait_done("borrow_chain", 2);

        start_op(32'h80000000, 32'h00000001, 1'b0);
        wait_done("overflow", 2);
        start_op(32'd5, 32'd5, 1'b1);
        wait_done("neg_borrow", 2);
        check_idle_edge("neg_borrow");

        start_op(32'hCAFEBABE, 32'hCAFEBABE, 1'b0);
        wait_done("zero", 2);
        start_op(32'd3, 32'd1, 1'b0);
        wait_done("back_to_back", 2);

        start_op(32'd9, 32'd4, 1'b0);
        Start = 1'b1; A = 32'd0; B = 32'd0; Bin = 1'b0;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("ignore_busy", 64'(Busy), 64'd1);
        wait_done("ignore_start", 1);

        // Abort mid-operation once slice 0 already holds a non-zero value.
        start_op(32'h0000FFFF, 32'h00000000, 1'b0);
        @(posedge Clk); #2;
        check("abort_partial_d", 64'(D[15:0]), 64'hFFFF);
        Reset = 1'b1;
        #1;
        check_cleared("async_reset");
        @(posedge Clk); #1;
        check_cleared("reset_hold");
        @(negedge Clk); Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check_cleared("post_reset");
        end

        start_op(32'h00000000, 32'h00000001, 1'b1);
        wait_done("after_reset", 2);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000 ^ 32'($urandom_range(0, 3));
            start_op(ra, rb, 1'($urandom_range(0, 1)));
            wait_done("random", 2);
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) check_idle_edge("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
